// File: rtl/dram_bridge_if.sv
// CPU data-port bus between the core (master) and the memory-side responder (slave).
// Read data is combinational from the address, so one cycle completes one access.
interface dram_bridge_if;
  logic [15:0] x_addr;
  logic        x_dram_wen;
  logic [31:0] x_dram_wdata;
  logic [31:0] dram_rdata;

  modport master (
    output x_addr,
    output x_dram_wen,
    output x_dram_wdata,
    input  dram_rdata
  );

  modport slave (
    input  x_addr,
    input  x_dram_wen,
    input  x_dram_wdata,
    output dram_rdata
  );
endinterface

// File: rtl/dram_bridge.sv
// Memory-side responder for the CPU data port: word RAM plus a peripheral page at 0xF000
// holding the 7-seg display, LEDs, switch and button inputs, and a free-running cycle counter.
module dram_bridge #(
  parameter int RAM_AW   = 12,
  parameter int SCAN_DIV = 20000,
  parameter int SW_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  dram_bridge_if.slave      bus,
  input  logic [SW_W-1:0]   sw,
  input  logic [4:0]        btn,
  output logic [SW_W-1:0]   led,
  output logic [7:0]        seg_n,
  output logic [7:0]        dig_n
);

  // Peripheral offsets as word indices (byte offset >> 2).
  localparam logic [9:0] OFF_SEG = 10'h000;
  localparam logic [9:0] OFF_LED = 10'h018;
  localparam logic [9:0] OFF_SW  = 10'h01C;
  localparam logic [9:0] OFF_BTN = 10'h01E;
  localparam logic [9:0] OFF_CNT = 10'h020;

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic [31:0]       seg_q;
  logic [31:0]       cnt_q;
  logic [SW_W-1:0]   sw_p0, sw_p1;
  logic [4:0]        btn_p0, btn_p1;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        dig_idx;

  logic              is_periph;
  logic [9:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_periph;
  logic              unused_addr;

  assign is_periph   = (bus.x_addr[15:12] == 4'hF);
  assign off         = bus.x_addr[11:2];
  assign ram_idx     = bus.x_addr[RAM_AW+1:2];
  assign wr_periph   = bus.x_dram_wen && is_periph;
  assign unused_addr = ^bus.x_addr[1:0];

  // RAM has no reset; a same-cycle read sees the word before this edge.
  always_ff @(posedge clk) begin
    if (bus.x_dram_wen && !is_periph)
      mem[ram_idx] <= bus.x_dram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      led     <= '0;
      cnt_q   <= '0;
      sw_p0   <= '0;
      sw_p1   <= '0;
      btn_p0  <= '0;
      btn_p1  <= '0;
      div_q   <= '0;
      dig_idx <= '0;
    end else begin
      // stage p0 -> p1: two-flop synchronizers for the board inputs
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      btn_p0 <= btn;
      btn_p1 <= btn_p0;

      if (wr_periph && off == OFF_SEG) seg_q <= bus.x_dram_wdata;
      if (wr_periph && off == OFF_LED) led   <= bus.x_dram_wdata[SW_W-1:0];

      if (wr_periph && off == OFF_CNT) cnt_q <= '0;
      else                             cnt_q <= cnt_q + 32'd1;

      if (div_q == DIV_LAST) begin
        div_q   <= '0;
        dig_idx <= dig_idx + 3'd1;
      end else begin
        div_q   <= div_q + DIV_W'(1);
      end
    end
  end

  assign dig_n = ~(8'd1 << dig_idx);
  assign seg_n = hex7(seg_q[{dig_idx, 2'b00} +: 4]);

  always_comb begin
    bus.dram_rdata = '0;
    if (is_periph) begin
      case (off)
        OFF_SEG: bus.dram_rdata = seg_q;
        OFF_LED: bus.dram_rdata = 32'(led);
        OFF_SW:  bus.dram_rdata = 32'(sw_p1);
        OFF_BTN: bus.dram_rdata = {27'b0, btn_p1};
        OFF_CNT: bus.dram_rdata = cnt_q;
        default: bus.dram_rdata = '0;
      endcase
    end else begin
      bus.dram_rdata = mem[ram_idx];
    end
  end

endmodule

// File: doc/dram_bridge.md
Name: dram_bridge

Overview:
- Memory-side responder for the CPU data port: accepts the CPU's address, write-enable and write-data, and returns read data in the same cycle.
- Decodes the 16-bit byte address into two regions: a word-addressed data RAM, and a memory-mapped peripheral page. The page holds a 7-segment display register, LED register, switch and button inputs, and a free-running cycle counter.
- Sits between the CPU core and board I/O in the top-level SoC.

Parameters:
- RAM_AW, 12, word-address width of data RAM (depth 2^RAM_AW words).
- SCAN_DIV, 20000, clk cycles each 7-seg digit stays lit (must be >= 2).
- SW_W, 24, switch input width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- x_addr  input  16  byte address from CPU (bits [1:0] ignored).
- x_dram_wen  input  1  write enable, sampled at clk edge.
- x_dram_wdata  input  32  write data.
- dram_rdata  output  32  read data, combinational from x_addr and current state.
- sw  input  SW_W  board switches, asynchronous.
- btn  input  5  board buttons, asynchronous.
- led  output  SW_W  LED register.
- seg_n  output  8  segment drive {dp,g,f,e,d,c,b,a}, active-low.
- dig_n  output  8  digit enable, one-hot active-low.

Behaviour:
- Region select:
  - x_addr[15:12]==4'hF selects the peripheral page.
  - Any other value selects RAM, word index x_addr[RAM_AW+1:2]. Upper bits alias.
- RAM:
  - Reads are asynchronous; writes are synchronous on clk when x_dram_wen=1.
  - A read of the same address in the write cycle returns the old word.
  - Contents are not affected by rst.
- Peripheral map (x_addr[11:0]):
  - 0x000 SEG: R/W 32-bit, 8 hex nibbles; nibble k drives digit k.
  - 0x060 LED: R/W; write stores wdata[SW_W-1:0]; read returns zero-extended value.
  - 0x070 SW: RO; returns zero-extended synchronized switches.
  - 0x078 BTN: RO; returns {27'b0, synchronized btn}.
  - 0x080 CNT: 32-bit. Increments every cycle and wraps 0xFFFFFFFF->0. Any write sets it to 0 at that edge. Read returns the current value.
  - All other peripheral offsets read 0; writes to them and to RO registers are ignored.
- Synchronizers: sw and btn each pass through 2 flops. A change is visible on dram_rdata 2 edges after it is sampled.
- Display scanner:
  - A divider counter counts 0..SCAN_DIV-1. On terminal count it clears and the digit index (3-bit) advances, wrapping 7->0.
  - dig_n = ~(1<<index).
  - seg_n = hex pattern of SEG[4*index+3:4*index], dp always off (bit7=1).
  - Hex patterns 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - A SEG write takes effect on the lit digit from the next cycle.
- Reset values: SEG=0, LED=0, CNT=0, synchronizer flops=0, divider=0, index=0.
  - So after reset dig_n=8'hFE and seg_n=8'hC0.
  - dram_rdata follows the decode with reset state: peripheral reads give 0; RAM reads give RAM content.
- Simultaneous events:
  - CNT write wins over increment.
  - Reset wins over everything except RAM contents.
  - Reset asserted mid-scan returns to digit 0 on the next edge.
- No wait states: every access completes in one cycle. The CPU never stalls on this block.

Test Plan:
- Reset: hold rst 2 cycles -> led=0, dig_n=FE, seg_n=C0; read 0xF080 right after release returns 0, then 1, 2, ... on following cycles.
- RAM: write 0x12345678 to 0x0010, then read 0x0010 -> 0x12345678; read 0x1010 with RAM_AW=10 -> same word (alias); same-cycle write/read of 0x0014 returns prior value.
- LED/SW: write 0xABCDEF to 0xF060 -> led=0xABCDEF and read returns 0x00ABCDEF. Drive sw=0x5A5A5A -> read 0xF070 returns old value for 2 edges, then 0x005A5A5A. A write to 0xF070 has no effect.
- Counter: let CNT reach 100, write 0xF080 -> next read 0. Force CNT to 0xFFFFFFFF via one extra free-run cycle in a shortened-width test -> wraps to 0.
- Display: SCAN_DIV=4, SEG=0x76543210 -> dig_n steps FE,FD,FB,...,7F,FE every 4 cycles, and seg_n=C0,F9,A4,B0,99,92,82,F8 in step with it.
- Unmapped: read 0xF004 -> 0; write 0xDEAD to 0xF004 -> SEG, LED and CNT unchanged.
